// File: rtl/compl_pair_monitor_if.sv
// Signal bundle between a complementary-pair source and its monitor.
// The source drives the pair and controls; the monitor returns counters and flags.
interface compl_pair_monitor_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             en;
    logic             clr;
    logic             a;
    logic             b;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail_pulse;
    logic             alarm;
    logic             checking;

    modport master (
        output en, clr, a, b,
        input  pass_cnt, fail_cnt, fail_pulse, alarm, checking
    );

    modport slave (
        input  en, clr, a, b,
        output pass_cnt, fail_cnt, fail_pulse, alarm, checking
    );
endinterface

// File: rtl/compl_pair_monitor.sv
// Cycle-based checker for a complementary pair (b must equal !a), with a settle
// window after every edge on a and a sticky alarm after a run of failures.
module compl_pair_monitor #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FAIL_LIMIT = 3,
    parameter int unsigned SETTLE     = 2
) (
    input  logic                clk,
    input  logic                rst,
    compl_pair_monitor_if.slave bus
);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned CW = $clog2(FAIL_LIMIT + 1);

    localparam logic [SW-1:0]    SETTLE_V   = SW'(SETTLE);
    localparam logic [SW-1:0]    SETTLE_ONE = SW'(1);
    localparam logic [CW-1:0]    LIMIT_V    = CW'(FAIL_LIMIT);
    localparam logic [CW-1:0]    CONS_ONE   = CW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StAlarm} state_e;

    state_e           r_state;
    logic             r_a_q;
    logic [SW-1:0]    r_settle;
    logic [CW-1:0]    r_cons;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_fail_pulse;
    logic             r_alarm;
    logic             r_checking;

    logic w_edge;
    logic w_settle_edge;
    logic w_pair_ok;

    assign w_edge        = bus.a ^ r_a_q;
    // With no settle window an edge cycle is evaluated like any other.
    assign w_settle_edge = w_edge && (SETTLE != 0);
    assign w_pair_ok     = bus.b ^ bus.a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_a_q        <= 1'b0;
            r_settle     <= '0;
            r_cons       <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_fail_pulse <= 1'b0;
            r_alarm      <= 1'b0;
            r_checking   <= 1'b0;
        end else begin
            r_a_q        <= bus.a;
            r_fail_pulse <= 1'b0;
            if (bus.clr) begin
                r_state    <= StIdle;
                r_settle   <= '0;
                r_cons     <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_alarm    <= 1'b0;
                r_checking <= 1'b0;
            end else if (!bus.en) begin
                if (r_state != StAlarm) begin
                    r_state    <= StIdle;
                    r_checking <= 1'b0;
                end
            end else begin
                case (r_state)
                    StIdle: begin
                        if (SETTLE == 0) begin
                            r_state    <= StCheck;
                            r_checking <= 1'b1;
                        end else begin
                            r_state  <= StSettle;
                            r_settle <= SETTLE_V;
                        end
                    end
                    StSettle: begin
                        if (w_edge) begin
                            r_settle <= SETTLE_V;
                        end else if (r_settle == SETTLE_ONE) begin
                            r_state    <= StCheck;
                            r_checking <= 1'b1;
                        end else begin
                            r_settle <= r_settle - SETTLE_ONE;
                        end
                    end
                    StCheck: begin
                        if (w_settle_edge) begin
                            r_state    <= StSettle;
                            r_settle   <= SETTLE_V;
                            r_checking <= 1'b0;
                        end else if (w_pair_ok) begin
                            if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
                            r_cons <= '0;
                        end else begin
                            if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                            r_fail_pulse <= 1'b1;
                            if (r_cons >= LIMIT_V - CONS_ONE) begin
                                r_cons     <= LIMIT_V;
                                r_state    <= StAlarm;
                                r_alarm    <= 1'b1;
                                r_checking <= 1'b0;
                            end else begin
                                r_cons <= r_cons + CONS_ONE;
                            end
                        end
                    end
                    StAlarm: begin
                        r_state <= StAlarm;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.pass_cnt   = r_pass_cnt;
    assign bus.fail_cnt   = r_fail_cnt;
    assign bus.fail_pulse = r_fail_pulse;
    assign bus.alarm      = r_alarm;
    assign bus.checking   = r_checking;
endmodule

// File: doc/compl_pair_monitor.md
Name: compl_pair_monitor

Overview:
Clocked checker that consumes a complementary signal pair (a, b = !a) and continuously verifies b != a. It is the synthesizable, cycle-based successor to our combinational immediate-assertion check. It counts passing and failing samples and ignores a settle window after every edge on a. It raises a sticky alarm after a run of consecutive failures; software or the bench clears the alarm.

Parameters:
CNT_W, 16, width of pass_cnt and fail_cnt (min 2)
FAIL_LIMIT, 3, consecutive failing samples that trigger alarm (min 1)
SETTLE, 2, clock cycles ignored after an edge on a (0 = no settle window)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  monitor enable; level-sensitive
clr  input  1  synchronous clear of counters, alarm and FSM
a  input  1  primary signal of pair, synchronous to clk
b  input  1  complement signal of pair, synchronous to clk
pass_cnt  output  CNT_W  number of samples with b != a
fail_cnt  output  CNT_W  number of samples with b == a
fail_pulse  output  1  one-cycle pulse per failing sample
alarm  output  1  sticky; FAIL_LIMIT consecutive failures seen
checking  output  1  high while FSM is in CHECK

Behaviour:
- Single clock domain. rst is asynchronous and active-high. No input synchronizers: a and b are already synchronous to clk.
- Reset values: pass_cnt=0, fail_cnt=0, fail_pulse=0, alarm=0, checking=0, FSM=IDLE, a_q=0, settle counter=0, consecutive-fail counter=0.
- a_q is a registered copy of a, updated every cycle in every state. An edge is a != a_q.
- Priority order: rst > clr > en=0 > FSM logic.
- clr (sync) has the following effect:
  - pass_cnt, fail_cnt and consecutive-fail counter go to 0.
  - fail_pulse and alarm go to 0.
  - FSM goes to IDLE.
  - clr is honoured in every state, including ALARM.
- en=0 in SETTLE or CHECK: next state is IDLE. Counters hold.
- en=0 in ALARM: state stays ALARM.
- States:
  - IDLE: checking=0. If en=1, load settle counter with SETTLE and go to SETTLE. If SETTLE=0, go directly to CHECK.
  - SETTLE: no evaluation. On an edge, reload the counter with SETTLE. Otherwise decrement. When the counter is 1 and there is no edge, the next state is CHECK.
  - CHECK: checking=1.
    - Edge on a: no evaluation. Go to SETTLE (or stay in CHECK if SETTLE=0, where the edge cycle is evaluated normally).
    - No edge, b != a: pass_cnt+1, consecutive-fail counter cleared.
    - No edge, b == a: fail_cnt+1, fail_pulse=1 next cycle, consecutive-fail counter+1.
    - When the consecutive-fail counter reaches FAIL_LIMIT, go to ALARM; alarm=1 in the same cycle the failing count updates.
  - ALARM: alarm=1, checking=0. Counters frozen, no evaluation, no fail_pulse. Exit only via clr or rst.
- Latency: a sample evaluated in cycle N appears in pass_cnt, fail_cnt and fail_pulse at cycle N+1 (all outputs registered).
- Counters saturate at 2^CNT_W-1 and do not wrap. The consecutive-fail counter saturates at FAIL_LIMIT.
- Simultaneous en rising and clr: clr wins; the FSM stays IDLE for that cycle.
- rst asserted mid-CHECK or mid-ALARM: all outputs reach reset values immediately, without waiting for a clock edge.

Test Plan:
1. Steady pass (defaults): rst, a=1, b=0, en=1 at cycle 0 → cycles 1–2 SETTLE; checking=1 from cycle 3; after 10 CHECK cycles pass_cnt=10, fail_cnt=0, alarm=0.
2. Toggling pair: a toggles every 5 cycles, b=!a, 40 cycles with en=1 → fail_cnt=0; no evaluation in the 2 cycles following each edge; pass_cnt equals the non-settle CHECK cycles (bench model).
3. Transient fault: in CHECK, force b=a for 2 cycles, then restore → fail_cnt=2, two fail_pulse cycles, alarm=0; consecutive counter reset on the next passing sample.
4. Alarm and clear: force b=a for 3 cycles → alarm=1 on the third update, fail_cnt=3; hold the fault 5 more cycles → fail_cnt stays 3; pulse clr → all counters 0, alarm=0, FSM=IDLE; en still 1 → SETTLE next cycle.
5. Saturation: CNT_W=4, 20 passing samples → pass_cnt=15, no wrap.
6. Async reset: assert rst between clock edges mid-CHECK with pass_cnt=7 → pass_cnt=0 and checking=0 immediately. After release, behaviour matches scenario 1.
